decoder_scan_sequencer: RTL and testbench
=========================================

DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000: cycles each channel is enabled; legal range >= 1.
REQ-002 Parameter BLANK_CYCLES, default 2: disabled cycles before each channel's dwell; legal range >= 0.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port run  input  1: level; 1 = scan, 0 = stop.
REQ-006 Port mask  input  4: channel i is scanned only when mask[i]=1.
REQ-007 Port sel  output  2: channel index; drives the 2-to-4 decoder x input.
REQ-008 Port sel_en  output  1: drives the decoder enable input; 1 only during a dwell.
REQ-009 Port frame_done  output  1: one-cycle pulse at the end of a frame.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-011 The FSM SHALL have exactly three states: IDLE, BLANK and ACTIVE.
REQ-012 In IDLE, the block SHALL drive sel=0, sel_en=0 and frame_done=0.
REQ-013 IDLE SHALL move to BLANK at the edge where run=1 and mask!=0, loading sel with the lowest-index set mask bit and clearing the cycle counter.
REQ-014 In BLANK, sel_en SHALL be 0; after BLANK_CYCLES cycles the FSM SHALL enter ACTIVE, and with BLANK_CYCLES=0 it SHALL go directly to ACTIVE, skipping BLANK.
REQ-015 In ACTIVE, sel_en SHALL be 1 for exactly DWELL_CYCLES consecutive cycles, with sel stable throughout.
REQ-016 At the end of ACTIVE, sel SHALL advance to the next set mask bit in ascending index order, wrapping 3->0, and the FSM SHALL enter BLANK (or ACTIVE when BLANK_CYCLES=0).
REQ-017 frame_done SHALL be 1 for the single cycle following the end of the dwell on the highest-index set mask bit.
REQ-018 When exactly one mask bit is set, the sequencer SHALL rescan the same channel, with the blank gap and a frame_done pulse every dwell.
REQ-019 A mask change SHALL be sampled only at the dwell-end advance; the channel currently dwelling SHALL finish its full dwell even if its mask bit is cleared.
REQ-020 When mask==0 at an advance point, the FSM SHALL go to IDLE with sel_en=0.
REQ-021 When run=0 is sampled in any state, the FSM SHALL enter IDLE at that edge (sel_en=0 next cycle), without completing the dwell and without a frame_done pulse.
REQ-022 When run is reasserted after a stop, scanning SHALL restart from the lowest set mask bit, not resume.
REQ-023 The cycle counter SHALL be $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits wide, SHALL be cleared on every state entry, and SHALL never wrap.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with sel=0, sel_en=0, frame_done=0 and counter=0, applied immediately without waiting for a clock edge.
REQ-025 Reset asserted mid-dwell SHALL drop sel_en to 0 asynchronously.
REQ-026 After rst_n deasserts, the first scan SHALL start on the first clock edge that samples run=1.

Structure
REQ-027 The state encodings (IDLE=2'd0, BLANK=2'd1, ACTIVE=2'd2) and the default DWELL/BLANK constants SHALL reside in the shared package scan_pkg.
REQ-028 The next-channel search SHALL be a combinational sub-module, scan_next_channel (inputs cur[1:0], mask[3:0], from_start; outputs nxt[1:0], wrap, none).
REQ-029 The sequencer SHALL take sel and sel_en straight from its registers and connect them to decoder_2_to_4 x and enable without intervening logic.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated)
REQ-030 Scenario 1, full scan: mask=4'b1111, run=1 -> per channel 2 cycles sel_en=0 then 4 cycles sel_en=1; sel order 0,1,2,3,0; frame_done pulses once after the channel-3 dwell, period 24 cycles.
REQ-031 Scenario 2, sparse mask: mask=4'b1010 -> sel alternates 1,3,1; frame_done follows each channel-3 dwell; channels 0 and 2 are never enabled.
REQ-032 Scenario 3, mid-dwell mask change: during the channel-1 dwell, set mask 4'b1111->4'b0001 -> channel 1 completes 4 enabled cycles, then sel=0 and 0 is rescanned indefinitely.
REQ-033 Scenario 4, stop mid-dwell: run=0 in the 2nd dwell cycle -> sel_en=0 the next cycle, sel=0, no frame_done; run=1 again -> restart at the lowest set bit after 2 blank cycles.
REQ-034 Scenario 5, reset mid-dwell: rst_n=0 asynchronously mid-dwell -> sel_en falls without a clock edge; after release, outputs hold 0 until run=1 is sampled.
REQ-035 Scenario 6, edge parameters: BLANK_CYCLES=0, DWELL_CYCLES=1, mask=4'b1111 -> sel_en is constantly 1 and sel increments every cycle 0,1,2,3,0; also mask=0 with run=1 -> FSM stays IDLE.

Source files
------------

// File: rtl/scan_pkg.sv
//------------------------------------------------------------------------------
// Module      : scan_pkg
// Description : Shared state encoding, default timing constants and counter
//               width helper for the decoder scan sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } scan_state_t;

    localparam int DEFAULT_DWELL_CYCLES = 1000;
    localparam int DEFAULT_BLANK_CYCLES = 2;

    // Sized to hold the larger of the two phase lengths so the counter never wraps.
    function automatic int cnt_width(input int dwell, input int blank);
        return $clog2(((dwell > blank) ? dwell : blank) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_next_channel.sv
//------------------------------------------------------------------------------
// Module      : scan_next_channel
// Description : Combinational search for the next enabled channel in
//               ascending order, or the lowest enabled channel from start.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_next_channel
    import scan_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [3:0] mask,
    input  logic       from_start,
    output logic [1:0] nxt,
    output logic       wrap,
    output logic       none
);

    logic [1:0] w_idx;
    logic [1:0] w_nxt;
    logic       w_found;

    // From start the candidates are 0..3; otherwise cur+1..cur+4 so that a
    // lone set bit finds the current channel again.
    always_comb begin
        w_idx   = 2'd0;
        w_nxt   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = from_start ? 2'(k) : 2'(cur + 2'(k + 1));
            if (!w_found && mask[w_idx]) begin
                w_found = 1'b1;
                w_nxt   = w_idx;
            end
        end
    end

    assign nxt  = w_nxt;
    assign none = !w_found;
    assign wrap = !from_start && w_found && (w_nxt <= cur);

endmodule

`default_nettype wire

// File: rtl/decoder_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module      : decoder_scan_sequencer
// Description : Cycles a 2-to-4 decoder through the masked channels with a
//               blank gap before each dwell and a per-frame done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decoder_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       frame_done
);

    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam bit               c_no_blank   = (BLANK_CYCLES == 0);

    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic             r_sel_en;
    logic             r_frame_done;

    logic [1:0]       w_nxt;
    logic             w_wrap;
    logic             w_none;

    // From IDLE the search starts at channel 0 so a restart never resumes.
    scan_next_channel u_next (
        .cur        (r_sel),
        .mask       (mask),
        .from_start (r_state == S_IDLE),
        .nxt        (w_nxt),
        .wrap       (w_wrap),
        .none       (w_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_sel_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!run) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_sel    <= 2'd0;
                r_sel_en <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_none) begin
                            r_sel <= w_nxt;
                            r_cnt <= '0;
                            if (c_no_blank) begin
                                r_state  <= S_ACTIVE;
                                r_sel_en <= 1'b1;
                            end else begin
                                r_state  <= S_BLANK;
                            end
                        end
                    end
                    S_BLANK: begin
                        if (r_cnt == c_blank_last) begin
                            r_state  <= S_ACTIVE;
                            r_sel_en <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    S_ACTIVE: begin
                        // Mask is only consulted here, so a cleared bit never cuts a dwell short.
                        if (r_cnt == c_dwell_last) begin
                            r_cnt <= '0;
                            if (w_none) begin
                                r_state  <= S_IDLE;
                                r_sel    <= 2'd0;
                                r_sel_en <= 1'b0;
                            end else begin
                                r_sel        <= w_nxt;
                                r_frame_done <= w_wrap;
                                if (c_no_blank) begin
                                    r_state  <= S_ACTIVE;
                                    r_sel_en <= 1'b1;
                                end else begin
                                    r_state  <= S_BLANK;
                                    r_sel_en <= 1'b0;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_sel    <= 2'd0;
                        r_sel_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel        = r_sel;
    assign sel_en     = r_sel_en;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_decoder_scan_sequencer
// Description : Self-checking bench for two sequencer configurations against
//               a segment-position reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, fd_a, fd_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per DUT, whether scanning, current channel, position
    // within the blank+dwell segment, and whether this segment opened a frame.
    bit m_run [2];
    int m_ch  [2];
    int m_pos [2];
    bit m_fd  [2];

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .sel(sel_a), .sel_en(en_a), .frame_done(fd_a)
    );

    decoder_scan_sequencer #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .sel(sel_b), .sel_en(en_b), .frame_done(fd_b)
    );

    function automatic int pd(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int pb(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_ch(input int c, input logic [3:0] m);
        for (int d = 1; d <= 4; d++) if (m[(c + d) % 4]) return (c + d) % 4;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_ch[k]  = 0;
            m_pos[k] = 0;
            m_fd[k]  = 1'b0;
        end
    endtask

    task automatic model_tick(input int k);
        int nc;
        if (!run) begin
            m_run[k] = 1'b0;
        end else if (!m_run[k]) begin
            if (mask != 4'd0) begin
                m_run[k] = 1'b1;
                m_ch[k]  = lowest(mask);
                m_pos[k] = 0;
                m_fd[k]  = 1'b0;
            end
        end else begin
            m_pos[k]++;
            if (m_pos[k] == pb(k) + pd(k)) begin
                if (mask == 4'd0) begin
                    m_run[k] = 1'b0;
                end else begin
                    nc       = next_ch(m_ch[k], mask);
                    m_fd[k]  = (nc <= m_ch[k]);
                    m_ch[k]  = nc;
                    m_pos[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] es, een, efd;
        for (int k = 0; k < 2; k++) begin
            es  = m_run[k] ? 4'(m_ch[k]) : 4'd0;
            een = (m_run[k] && m_pos[k] >= pb(k)) ? 4'd1 : 4'd0;
            efd = (m_run[k] && m_fd[k] && m_pos[k] == 0) ? 4'd1 : 4'd0;
            chk($sformatf("%s.dut%0d.sel", tag, k), {2'b00, (k == 0) ? sel_a : sel_b}, es);
            chk($sformatf("%s.dut%0d.sel_en", tag, k), {3'b000, (k == 0) ? en_a : en_b}, een);
            chk($sformatf("%s.dut%0d.frame_done", tag, k), {3'b000, (k == 0) ? fd_a : fd_b}, efd);
        end
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_tick(0);
            model_tick(1);
            #1;
            check_all(tag);
        end
    endtask

    task automatic guard(input string tag, input bit ok);
        if (!ok) begin
            n_fail++;
            $error("FAIL %s observed=timeout expected=condition reached", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        mask  = 4'd0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset_idle", 3);

        // Full scan, channels 0..3.
        mask = 4'b1111;
        run  = 1'b1;
        step("full_scan", 60);

        // Sparse mask takes effect at the next dwell-end advance.
        mask = 4'b1010;
        step("sparse", 60);

        // Restart full, then shrink mask during the channel-1 dwell.
        run = 1'b0;
        step("stop", 1);
        mask = 4'b1111;
        run  = 1'b1;
        for (int i = 0; i < 40 && !(m_run[0] && m_ch[0] == 1 && m_pos[0] >= 2); i++)
            step("to_ch1", 1);
        guard("reach_ch1_dwell", m_run[0] && m_ch[0] == 1 && m_pos[0] >= 2);
        mask = 4'b0001;
        step("mask_change", 40);

        // Stop during the second dwell cycle, then restart.
        mask = 4'b1111;
        run  = 1'b0;
        step("stop2", 1);
        run = 1'b1;
        for (int i = 0; i < 40 && !(m_run[0] && m_pos[0] == 3); i++)
            step("to_dwell2", 1);
        guard("reach_dwell2", m_run[0] && m_pos[0] == 3);
        run = 1'b0;
        step("stop_mid_dwell", 2);
        run = 1'b1;
        step("restart", 12);

        // Empty mask keeps the sequencer idle.
        run = 1'b0;
        step("stop3", 1);
        mask = 4'd0;
        run  = 1'b1;
        step("empty_mask", 8);

        // Asynchronous reset in the middle of a dwell.
        mask = 4'b1111;
        for (int i = 0; i < 40 && !(m_run[0] && m_pos[0] == 3); i++)
            step("to_dwell_rst", 1);
        guard("reach_dwell_rst", m_run[0] && m_pos[0] == 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("in_reset");
        run   = 1'b0;
        rst_n = 1'b1;
        step("after_release", 3);
        run = 1'b1;
        step("after_release_run", 20);

        // Random mask changes and occasional stops.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
            run = ($urandom_range(0, 29) != 0);
            step("random", 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
